// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and read-side FSM states for the async FIFO consumer
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH = 16;
  localparam int SKID_DEPTH = 3;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} rd_state_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: small circular buffer that decouples FIFO reads from stream backpressure
module fifo_rd_skid #(
  parameter int W = 8,
  parameter int DEPTH = 3,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  output logic [OW-1:0] o_occ,
  output logic [W-1:0]  o_head
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [OW-1:0] r_occ;
  logic [PW-1:0] w_head_nxt, w_tail_nxt;
  assign w_head_nxt = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail <= w_tail_nxt;
      end
      if (i_pop) r_head <= w_head_nxt;
      r_occ <= r_occ + OW'(i_push) - OW'(i_pop);
    end
  end
  assign o_occ = r_occ;
  assign o_head = r_mem[r_head];
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops the async FIFO read port and re-times words onto a valid/ready stream
module fifo_rd_stream #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH = fifo_pkg::CNT_WIDTH,
  parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  import fifo_pkg::*;
  localparam int OW = $clog2(SKID_DEPTH + 1);
  if (SKID_DEPTH < 3) begin : g_depth_chk
    $error("SKID_DEPTH must be at least 3 to sustain one word per clock");
  end
  rd_state_e r_state, w_state_nxt;
  logic r_inflight;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [OW-1:0] w_occ;
  logic w_pop;
  // Room check counts the word already in flight so the buffer can never overflow
  assign fifo_rd_en = (r_state == ACTIVE) && !fifo_empty
                      && (int'(w_occ) + int'(r_inflight) < SKID_DEPTH);
  assign w_pop = m_valid && m_ready;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = en ? ACTIVE : IDLE;
      ACTIVE:  w_state_nxt = en ? ACTIVE : DRAIN;
      DRAIN:   w_state_nxt = en ? ACTIVE : (!r_inflight && w_occ == '0) ? IDLE : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_inflight <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_inflight <= fifo_rd_en;
      r_cnt <= r_cnt + CNT_WIDTH'(w_pop);
    end
  end
  fifo_rd_skid #(.W(DATA_WIDTH), .DEPTH(SKID_DEPTH)) u_skid (
    .clk         (clk_rd),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_data),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (m_data)
  );
  assign m_valid = (w_occ != '0);
  assign busy = (r_state != IDLE) || (w_occ != '0);
  assign word_cnt = r_cnt;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: random and directed stimulus against a FIFO model and an in-order word scoreboard
module tb_fifo_rd_stream;
  import fifo_pkg::*;
  logic clk_rd = 1'b0, rst_n = 1'b0, en = 1'b0, m_ready = 1'b0;
  logic fifo_empty, fifo_rd_en, m_valid, busy;
  logic [7:0] fifo_data = 8'h00, m_data;
  logic [15:0] word_cnt;
  logic en4 = 1'b0, m_ready4 = 1'b1, empty4 = 1'b0, rd4, mv4, busy4;
  logic [7:0] data4 = 8'h00, md4;
  logic [3:0] wc4;
  logic [7:0] mem [1024];
  int wr_ptr = 0, rd_ptr = 0;
  int n_cmp = 0, n_err = 0;
  int hs = 0, issued = 0, exp_idx = 0, hs4 = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk_rd = ~clk_rd;

  fifo_rd_stream dut (
    .clk_rd(clk_rd), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .word_cnt(word_cnt)
  );
  fifo_rd_stream #(.CNT_WIDTH(4)) dut4 (
    .clk_rd(clk_rd), .rst_n(rst_n), .en(en4), .fifo_empty(empty4), .fifo_data(data4),
    .fifo_rd_en(rd4), .m_valid(mv4), .m_ready(m_ready4), .m_data(md4),
    .busy(busy4), .word_cnt(wc4)
  );

  // FIFO read port model: data appears one clock after the pop request; reset empties it
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end
  always @(posedge clk_rd) if (rd4) data4 <= data4 + 8'h01;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_rd);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  // Scoreboard: words must leave in the order they were written, counted per handshake
  always @(negedge clk_rd) begin
    if (!rst_n) begin
      hs = 0; issued = 0; hs4 = 0; exp_idx = wr_ptr; prev_stall = 1'b0;
    end else begin
      chk("rd_when_empty", 32'(fifo_rd_en && fifo_empty), 0);
      chk("word_cnt", 32'(word_cnt), hs & 32'hffff);
      chk("word_cnt4", 32'(wc4), hs4 % 16);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (fifo_rd_en) issued++;
      chk("outstanding_le3", 32'(issued - hs <= 3), 1);
      if (m_valid && m_ready) begin
        chk("data", 32'(m_data), 32'(mem[exp_idx]));
        exp_idx++;
        hs++;
      end
      if (mv4) hs4++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    int t1, t2, n, k, is0, hs0, ka, kb;
    logic [3:0] w [30];
    #3;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_cnt", 32'(word_cnt), 0);
    tick(); tick(); #1 rst_n = 1'b1;
    // 4-bit counter wrap
    en4 = 1'b1;
    for (int i = 0; i < 30; i++) begin tick(); w[i] = wc4; end
    k = -1;
    for (int i = 0; i < 28; i++) if (k < 0 && w[i] == 4'd15) k = i;
    chk("wrap_found", 32'(k >= 0), 1);
    if (k >= 0) begin
      chk("wrap_15_to_0", 32'(w[k+1]), 0);
      chk("wrap_0_to_1", 32'(w[k+2]), 1);
    end
    #1 en4 = 1'b0;
    // preloaded stream
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    m_ready = 1'b1; en = 1'b1;
    t1 = 0;
    for (int i = 0; i < 20 && !fifo_rd_en; i++) begin tick(); t1++; end
    chk("first_rd_en_seen", 32'(fifo_rd_en), 1);
    t2 = t1;
    for (int i = 0; i < 20 && !m_valid; i++) begin tick(); t2++; end
    chk("first_valid_latency", 32'(t2 - t1), 2);
    n = 0;
    for (int i = 0; i < 16; i++) begin if (m_valid && m_ready) n++; tick(); end
    chk("one_word_per_clk", 32'(n), 16);
    chk("cnt_after_16", 32'(word_cnt), 16);
    chk("stream_empty_after", 32'(m_valid), 0);
    // backpressure mid-stream
    #1 for (int i = 0; i < 20; i++) push_word(8'($urandom));
    repeat (4) tick();
    #1 m_ready = 1'b0;
    repeat (6) tick();
    chk("bp_rd_en_off", 32'(fifo_rd_en), 0);
    chk("bp_outstanding", 32'(issued - hs), 3);
    chk("bp_valid_held", 32'(m_valid), 1);
    repeat (4) tick();
    #1 m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_idx != wr_ptr; i++) tick();
    chk("bp_all_delivered", 32'(exp_idx), 32'(wr_ptr));
    // random traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      tick();
      #1 m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
    end
    m_ready = 1'b1;
    for (int i = 0; i < 400 && exp_idx != wr_ptr; i++) tick();
    chk("rand_all_delivered", 32'(exp_idx), 32'(wr_ptr));
    // FIFO running empty
    is0 = issued;
    #1 push_word(8'hA1); push_word(8'hA2);
    repeat (10) tick();
    chk("empty_two_reads", 32'(issued - is0), 2);
    chk("empty_rd_en_low", 32'(fifo_rd_en), 0);
    #1 push_word(8'hA3);
    repeat (6) tick();
    chk("empty_resume", 32'(issued - is0), 3);
    chk("empty_delivered", 32'(exp_idx), 32'(wr_ptr));
    // drain with one word in flight and two buffered
    #1 m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'($urandom));
    for (int i = 0; i < 20 && issued - hs != 3; i++) tick();
    chk("drain_setup", 32'(issued - hs), 3);
    #1 en = 1'b0; m_ready = 1'b1;
    is0 = issued; hs0 = hs; ka = -1; kb = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ka < 0 && !m_valid) ka = i;
      if (kb < 0 && !busy) kb = i;
    end
    chk("drain_no_rd_en", 32'(issued - is0), 0);
    chk("drain_words", 32'(hs - hs0), 3);
    chk("drain_busy_lag", 32'(kb - ka), 1);
    chk("drain_busy_low", 32'(busy), 0);
    chk("drain_idle", 32'(dut.r_state), 32'(IDLE));
    // reset with two words buffered
    #1 push_word(8'hB1); push_word(8'hB2); push_word(8'hB3);
    m_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 20 && issued - hs != 3; i++) tick();
    chk("rst_setup", 32'(issued - hs), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(m_valid), 0);
    chk("rst_mid_data", 32'(m_data), 0);
    chk("rst_mid_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_cnt", 32'(word_cnt), 0);
    tick(); tick();
    #1 en = 1'b0; m_ready = 1'b1; rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); n += int'(m_valid) + int'(busy); end
    chk("no_stray_after_rst", 32'(n), 0);
    // traffic after reset
    #1 for (int i = 0; i < 6; i++) push_word(8'($urandom));
    en = 1'b1;
    for (int i = 0; i < 100 && exp_idx != wr_ptr; i++) tick();
    chk("post_rst_delivered", 32'(exp_idx), 32'(wr_ptr));
    chk("post_rst_cnt", 32'(word_cnt), 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
